// File: rtl/traffic_ctrl_nway.sv
// N-approach traffic-light controller: seconds prescaler, demand skip, emergency preemption.
// All outputs registered (one-cycle latency from inputs); no backpressure, inputs are levels.
module traffic_ctrl_nway #(
  parameter int N_DIR         = 4,
  parameter int TICKS_PER_SEC = 100000000,
  parameter int GREEN_SEC     = 10,
  parameter int YELLOW_SEC    = 4,
  parameter int ALLRED_SEC    = 1,
  localparam int DW = $clog2(N_DIR)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [N_DIR-1:0]   veh_req,
  input  logic               emerg_req,
  input  logic [DW-1:0]      emerg_dir,
  output logic [3*N_DIR-1:0] lights,
  output logic [DW-1:0]      active_dir,
  output logic [1:0]         phase,
  output logic               sec_tick
);

  localparam int PW   = $clog2(TICKS_PER_SEC);
  localparam int MGY  = (GREEN_SEC > YELLOW_SEC) ? GREEN_SEC : YELLOW_SEC;
  localparam int MAXD = (MGY > ALLRED_SEC) ? MGY : ALLRED_SEC;
  localparam int SW   = $clog2(MAXD + 1);
  localparam logic [PW-1:0] PRE_MAX  = PW'(TICKS_PER_SEC - 1);
  localparam logic [DW-1:0] LAST_DIR = DW'(N_DIR - 1);

  typedef enum logic [1:0] {
    ALLRED = 2'd0,
    GREEN  = 2'd1,
    YELLOW = 2'd2,
    EMERG  = 2'd3
  } state_t;

  state_t             state, state_n;
  logic [PW-1:0]      prescaler, prescaler_n;
  logic               tick_n;
  logic [SW-1:0]      sec_cnt, sec_cnt_n;
  logic [DW-1:0]      next_ptr, next_ptr_n;
  logic [DW-1:0]      dir_n, pick, scan;
  logic               found, emerg_ok;
  logic               green_done, yellow_done, allred_done;
  logic [3*N_DIR-1:0] lights_n;

  function automatic logic [DW-1:0] inc_dir(input logic [DW-1:0] d);
    return (d == LAST_DIR) ? '0 : d + 1'b1;
  endfunction

  function automatic logic [3*N_DIR-1:0] lamp(input state_t st, input logic [DW-1:0] d);
    logic [3*N_DIR-1:0] l;
    for (int i = 0; i < N_DIR; i++) begin
      l[3*i +: 3] = 3'b100;
      if (DW'(i) == d) begin
        case (st)
          GREEN, EMERG: l[3*i +: 3] = 3'b001;
          YELLOW:       l[3*i +: 3] = 3'b010;
          default:      l[3*i +: 3] = 3'b100;
        endcase
      end
    end
    return l;
  endfunction

  assign phase = state;

  always_comb begin
    prescaler_n = (prescaler == PRE_MAX) ? '0 : prescaler + 1'b1;
    tick_n      = (prescaler_n == PRE_MAX);
  end

  // Round-robin scan starting at next_ptr; falls back to next_ptr when nobody is waiting.
  always_comb begin
    pick  = next_ptr;
    found = 1'b0;
    scan  = next_ptr;
    for (int k = 0; k < N_DIR; k++) begin
      if (!found && veh_req[scan]) begin
        pick  = scan;
        found = 1'b1;
      end
      scan = inc_dir(scan);
    end
  end

  always_comb begin
    emerg_ok    = emerg_req && (int'(emerg_dir) < N_DIR);
    green_done  = sec_tick && (sec_cnt == SW'(GREEN_SEC - 1));
    yellow_done = sec_tick && (sec_cnt == SW'(YELLOW_SEC - 1));
    allred_done = sec_tick && (sec_cnt == SW'(ALLRED_SEC - 1));
  end

  always_comb begin
    state_n    = state;
    next_ptr_n = next_ptr;
    dir_n      = active_dir;
    sec_cnt_n  = sec_tick ? sec_cnt + 1'b1 : sec_cnt;
    case (state)
      ALLRED: begin
        if (allred_done) begin
          sec_cnt_n = '0;
          if (emerg_ok) begin
            state_n = EMERG;
            dir_n   = emerg_dir;
          end else begin
            state_n    = GREEN;
            dir_n      = pick;
            next_ptr_n = inc_dir(pick);
          end
        end
      end
      GREEN: begin
        // Preemption is checked every cycle, ahead of the normal timeout.
        if (emerg_ok && (emerg_dir != active_dir)) begin
          state_n   = YELLOW;
          sec_cnt_n = '0;
        end else if (emerg_ok) begin
          state_n   = EMERG;
          sec_cnt_n = '0;
        end else if (green_done) begin
          state_n   = YELLOW;
          sec_cnt_n = '0;
        end
      end
      YELLOW: begin
        if (yellow_done) begin
          state_n   = ALLRED;
          sec_cnt_n = '0;
        end
      end
      EMERG: begin
        sec_cnt_n = '0;
        if (!emerg_req) begin
          state_n    = YELLOW;
          next_ptr_n = inc_dir(active_dir);
        end
      end
      default: begin
        state_n   = ALLRED;
        sec_cnt_n = '0;
      end
    endcase
    lights_n = lamp(state_n, dir_n);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ALLRED;
      prescaler  <= '0;
      sec_tick   <= 1'b0;
      sec_cnt    <= '0;
      next_ptr   <= '0;
      active_dir <= '0;
      lights     <= {N_DIR{3'b100}};
    end else begin
      state      <= state_n;
      prescaler  <= prescaler_n;
      sec_tick   <= tick_n;
      sec_cnt    <= sec_cnt_n;
      next_ptr   <= next_ptr_n;
      active_dir <= dir_n;
      lights     <= lights_n;
    end
  end

endmodule

// File: tb/tb_traffic_ctrl_nway.sv
// Scoreboard bench: each scenario queues the expected sequence of light segments
// (phase, approach, lamps, length in cycles); a negedge monitor pops and compares.
module tb_traffic_ctrl_nway;

  localparam logic [2:0] LG = 3'b001;
  localparam logic [2:0] LY = 3'b010;
  localparam logic [2:0] LR = 3'b100;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  veh_req = '0;
  logic        emerg_req = 1'b0;
  logic [1:0]  emerg_dir = '0;
  logic [11:0] lights;
  logic [1:0]  active_dir;
  logic [1:0]  phase;
  logic        sec_tick;

  logic [2:0]  veh3 = '0;
  logic [1:0]  emerg_dir3 = 2'd3;
  logic [8:0]  lights3;
  logic [1:0]  active_dir3;
  logic [1:0]  phase3;
  logic        sec_tick3;

  always #5 clk = ~clk;

  traffic_ctrl_nway #(
    .N_DIR(4), .TICKS_PER_SEC(4), .GREEN_SEC(3), .YELLOW_SEC(2), .ALLRED_SEC(1)
  ) u_dut (
    .clk(clk), .reset_n(reset_n), .veh_req(veh_req), .emerg_req(emerg_req),
    .emerg_dir(emerg_dir), .lights(lights), .active_dir(active_dir),
    .phase(phase), .sec_tick(sec_tick)
  );

  traffic_ctrl_nway #(
    .N_DIR(3), .TICKS_PER_SEC(4), .GREEN_SEC(3), .YELLOW_SEC(2), .ALLRED_SEC(1)
  ) u_dut3 (
    .clk(clk), .reset_n(reset_n), .veh_req(veh3), .emerg_req(emerg_req),
    .emerg_dir(emerg_dir3), .lights(lights3), .active_dir(active_dir3),
    .phase(phase3), .sec_tick(sec_tick3)
  );

  typedef struct {
    int          ph;
    int          dir;
    logic [11:0] lt;
    int          len;   // 0: segment is cut short by the next scenario, length not checked
  } seg_t;

  typedef struct {
    int         cyc;
    int         ph;
    int         dir;
    logic [8:0] lt;
  } smp_t;

  seg_t exp_q[$];
  smp_t exp3[$];

  int chk_cnt = 0;
  int pass_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    chk_cnt++;
    if (act === want) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
  endtask

  function automatic logic [11:0] mk(input int d, input logic [2:0] c);
    logic [11:0] l;
    for (int i = 0; i < 4; i++) l[3*i +: 3] = (i == d) ? c : LR;
    return l;
  endfunction

  task automatic push_seg(input int ph, input int d, input logic [2:0] c, input int len);
    seg_t s;
    s.ph  = ph;
    s.dir = d;
    s.lt  = mk(d, c);
    s.len = len;
    exp_q.push_back(s);
  endtask

  task automatic push_smp(input int cyc, input int ph, input int d, input logic [8:0] lt);
    smp_t s;
    s.cyc = cyc;
    s.ph  = ph;
    s.dir = d;
    s.lt  = lt;
    exp3.push_back(s);
  endtask

  // Pulse reset for one edge with the scenario's inputs applied; returns in cycle 0.
  bit armed = 1'b0;
  task automatic start_scn(input logic [3:0] v, input logic er, input logic [1:0] ed);
    reset_n   = 1'b0;
    veh_req   = v;
    emerg_req = er;
    emerg_dir = ed;
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    armed   = 1'b1;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Monitor: cycle counter since reset release, segment tracker, N_DIR=3 sampler.
  int          cnt = 0;
  int          seg_len = 0;
  int          cur_len = 0;
  int          seg_no = 0;
  bit          have_seg = 1'b0;
  logic [15:0] prev_key;
  logic [15:0] cur_key;
  seg_t        e_cur;
  smp_t        e3;

  always @(negedge clk) begin
    if (armed) begin
      chk($sformatf("sec_tick@cyc%0d", cnt), 32'(sec_tick), 32'((cnt % 4) == 3));
      cur_key = {phase, active_dir, lights};
      if (!have_seg || cur_key != prev_key) begin
        if (have_seg && cur_len != 0)
          chk($sformatf("seg%0d_len", seg_no), 32'(seg_len), 32'(cur_len));
        seg_no++;
        chk($sformatf("seg%0d_expected", seg_no), 32'(exp_q.size() > 0), 32'd1);
        cur_len = 0;
        if (exp_q.size() > 0) begin
          e_cur   = exp_q.pop_front();
          cur_len = e_cur.len;
          chk($sformatf("seg%0d_phase", seg_no), 32'(phase), 32'(e_cur.ph));
          chk($sformatf("seg%0d_active_dir", seg_no), 32'(active_dir), 32'(e_cur.dir));
          chk($sformatf("seg%0d_lights", seg_no), 32'(lights), 32'(e_cur.lt));
        end
        prev_key = cur_key;
        seg_len  = 1;
        have_seg = 1'b1;
      end else begin
        seg_len++;
      end
      if (exp3.size() > 0 && exp3[0].cyc == cnt) begin
        e3 = exp3.pop_front();
        chk($sformatf("n3_phase@cyc%0d", cnt), 32'(phase3), 32'(e3.ph));
        chk($sformatf("n3_active_dir@cyc%0d", cnt), 32'(active_dir3), 32'(e3.dir));
        chk($sformatf("n3_lights@cyc%0d", cnt), 32'(lights3), 32'(e3.lt));
        chk($sformatf("n3_sec_tick@cyc%0d", cnt), 32'(sec_tick3), 32'((cnt % 4) == 3));
      end
    end
    cnt = (!reset_n) ? 0 : cnt + 1;
  end

  initial begin
    repeat (3) @(posedge clk);
    #2;

    // 1: no demand, fixed rotation 0,1,2,3,0; green 12, yellow 8, all-red 4 cycles
    push_seg(0, 0, LR, 4);
    for (int d = 0; d < 4; d++) begin
      push_seg(1, d, LG, 12);
      push_seg(2, d, LY, 8);
      push_seg(0, d, LR, 4);
    end
    push_seg(1, 0, LG, 0);
    start_scn(4'b0000, 1'b0, 2'd0);
    wait_cyc(104);

    // 2: only approach 2 asks, so only approach 2 is ever served
    start_scn(4'b0100, 1'b0, 2'd0);
    push_seg(0, 0, LR, 4);
    for (int r = 0; r < 2; r++) begin
      push_seg(1, 2, LG, 12);
      push_seg(2, 2, LY, 8);
      push_seg(0, 2, LR, 4);
    end
    push_seg(1, 2, LG, 0);
    wait_cyc(56);

    // 3: approaches 1 and 3 ask, they alternate
    start_scn(4'b1010, 1'b0, 2'd0);
    push_seg(0, 0, LR, 4);
    push_seg(1, 1, LG, 12); push_seg(2, 1, LY, 8); push_seg(0, 1, LR, 4);
    push_seg(1, 3, LG, 12); push_seg(2, 3, LY, 8); push_seg(0, 3, LR, 4);
    push_seg(1, 1, LG, 12); push_seg(2, 1, LY, 8); push_seg(0, 1, LR, 4);
    push_seg(1, 3, LG, 0);
    wait_cyc(80);

    // 4: emergency for approach 3 cuts approach 0's green; emerg_dir wiggle while held is ignored
    start_scn(4'b0000, 1'b0, 2'd0);
    push_seg(0, 0, LR, 4);
    push_seg(1, 0, LG, 4);
    push_seg(2, 0, LY, 8);
    push_seg(0, 0, LR, 4);
    push_seg(3, 3, LG, 8);
    push_seg(2, 3, LY, 8);
    push_seg(0, 3, LR, 4);
    push_seg(1, 0, LG, 0);
    wait_cyc(7);
    emerg_req = 1'b1;
    emerg_dir = 2'd3;
    wait_cyc(16);
    emerg_dir = 2'd1;
    wait_cyc(4);
    emerg_req = 1'b0;
    wait_cyc(17);

    // 5: emergency on the approach already green: lamps hold, phase goes to 3
    start_scn(4'b0000, 1'b0, 2'd0);
    push_seg(0, 0, LR, 4);
    push_seg(1, 0, LG, 3);
    push_seg(3, 0, LG, 5);
    push_seg(2, 0, LY, 8);
    push_seg(0, 0, LR, 4);
    push_seg(1, 1, LG, 0);
    wait_cyc(6);
    emerg_req = 1'b1;
    emerg_dir = 2'd0;
    wait_cyc(5);
    emerg_req = 1'b0;
    wait_cyc(17);

    // 6a: reset while in emergency; reset state must appear right after that edge
    start_scn(4'b0000, 1'b1, 2'd2);
    push_seg(0, 0, LR, 4);
    push_seg(3, 2, LG, 6);
    wait_cyc(9);

    // 6b: 3-approach instance sees emerg_dir=3 and must run the normal cycle
    start_scn(4'b0000, 1'b1, 2'd3);
    push_seg(0, 0, LR, 4);
    push_seg(3, 3, LG, 0);
    push_smp(2,  0, 0, 9'b100_100_100);
    push_smp(6,  1, 0, 9'b100_100_001);
    push_smp(15, 1, 0, 9'b100_100_001);
    push_smp(16, 2, 0, 9'b100_100_010);
    push_smp(26, 0, 0, 9'b100_100_100);
    push_smp(28, 1, 1, 9'b100_001_100);
    wait_cyc(30);

    chk("pending_segments", 32'(exp_q.size()), 32'd0);
    chk("pending_n3_samples", 32'(exp3.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
